// File: rtl/add_arbiter.sv
// Shares one adder/ALU datapath between two requesters (ADD_ARB_FIXED_PRIO_EN: fixed priority, else round-robin).
// Handshake to resp_valid is 2 cycles, one op per 3 cycles; resp_ready low holds RESP with resp_* stable.
module add_arbiter #(
  parameter int WIDTH  = 32,
  parameter int OP_LEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [OP_LEN-1:0] req0_opcode,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [OP_LEN-1:0] req1_opcode,
  output logic [WIDTH-1:0]  dp_a,
  output logic [WIDTH-1:0]  dp_b,
  output logic [OP_LEN-1:0] dp_opcode,
  input  logic [WIDTH-1:0]  dp_final_sum,
  input  logic              dp_cout,
  input  logic              dp_negative_flag,
  input  logic              dp_overflow_flag,
  input  logic              dp_zero_flag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [WIDTH-1:0]  resp_sum,
  output logic              resp_cout,
  output logic              resp_neg,
  output logic              resp_ovf,
  output logic              resp_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [OP_LEN-1:0] opcode;
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             neg;
    logic             ovf;
    logic             zero;
  } res_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_grant;
  logic   w_req_hs;
  logic   w_capture;
  op_t    w_req_sel;
  op_t    r_dp;
  res_t   r_resp;
  logic   r_resp_id;

`ifdef ADD_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid; no fairness history is kept.
  always_comb begin
    w_grant = ~req_valid[0] & req_valid[1];
  end
`else
  logic r_last_grant;

  always_comb begin
    w_grant = 1'b0;
    case (req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_req_hs) begin
      r_last_grant <= w_grant;
    end
  end
`endif

  always_comb begin
    if (w_grant) begin
      w_req_sel = '{a: req1_a, b: req1_b, opcode: req1_opcode};
    end else begin
      w_req_sel = '{a: req0_a, b: req0_b, opcode: req0_opcode};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    resp_valid  = 1'b0;
    w_req_hs    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // rst gating keeps ready low for the whole reset pulse, not just after the edge.
        w_req_hs = ~rst & req_valid[w_grant];
        req_ready[w_grant] = w_req_hs;
        if (w_req_hs) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp      <= '0;
      r_resp_id <= 1'b0;
    end else if (w_req_hs) begin
      r_dp      <= w_req_sel;
      r_resp_id <= w_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp <= '0;
    end else if (w_capture) begin
      r_resp <= '{sum:  dp_final_sum,
                  cout: dp_cout,
                  neg:  dp_negative_flag,
                  ovf:  dp_overflow_flag,
                  zero: dp_zero_flag};
    end
  end

  assign dp_a      = r_dp.a;
  assign dp_b      = r_dp.b;
  assign dp_opcode = r_dp.opcode;
  assign resp_id   = r_resp_id;
  assign resp_sum  = r_resp.sum;
  assign resp_cout = r_resp.cout;
  assign resp_neg  = r_resp.neg;
  assign resp_ovf  = r_resp.ovf;
  assign resp_zero = r_resp.zero;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: stub datapath beside the DUT, transaction-level model, directed literal checks.
module tb_add_arbiter;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        neg;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_opcode = '0, req1_opcode = '0;
  logic [31:0] dp_a, dp_b;
  logic [4:0]  dp_opcode;
  logic [31:0] dp_final_sum;
  logic        dp_cout, dp_negative_flag, dp_overflow_flag, dp_zero_flag;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_id;
  logic [31:0] resp_sum;
  logic        resp_cout, resp_neg, resp_ovf, resp_zero;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  add_arbiter #(.WIDTH(32), .OP_LEN(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_opcode(req0_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_opcode(req1_opcode),
    .dp_a(dp_a), .dp_b(dp_b), .dp_opcode(dp_opcode),
    .dp_final_sum(dp_final_sum), .dp_cout(dp_cout),
    .dp_negative_flag(dp_negative_flag), .dp_overflow_flag(dp_overflow_flag),
    .dp_zero_flag(dp_zero_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_neg(resp_neg),
    .resp_ovf(resp_ovf), .resp_zero(resp_zero)
  );

  // Stand-in datapath: 1 = unsigned add, 2 = negated sum, anything else = xor.
  function automatic res_t dp_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    res_t r;
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    case (op)
      5'd1: begin
        r.sum  = s[31:0];
        r.cout = s[32];
        r.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
      end
      5'd2:    r.sum = 32'd0 - s[31:0];
      default: r.sum = a ^ b;
    endcase
    r.neg  = r.sum[31];
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  always_comb begin
    res_t r;
    r = dp_model(dp_a, dp_b, dp_opcode);
    dp_final_sum     = r.sum;
    dp_cout          = r.cout;
    dp_negative_flag = r.neg;
    dp_overflow_flag = r.ovf;
    dp_zero_flag     = r.zero;
  end

  function automatic bit model_grant(input logic [1:0] v, input bit last);
`ifdef ADD_ARB_FIXED_PRIO_EN
    return (v == 2'b10);
`else
    if (v == 2'b11) return ~last;
    return v[1];
`endif
  endfunction

  // Transaction model: one operation in flight, result visible one edge after the EXEC edge.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  bit          m_last = 1'b1;
  bit          m_id   = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [4:0]  m_op = '0;
  res_t        m_exp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_last = 1'b1;
      m_a    = '0;
      m_b    = '0;
      m_op   = '0;
    end else if (!m_busy) begin
      bit g;
      g = model_grant(req_valid, m_last);
      if (req_valid[g]) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_last = g;
        m_id   = g;
        m_a    = g ? req1_a : req0_a;
        m_b    = g ? req1_b : req0_b;
        m_op   = g ? req1_opcode : req0_opcode;
        m_exp  = dp_model(m_a, m_b, m_op);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (resp_ready) begin
      m_busy = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] exp_rdy;
      bit g;
      exp_rdy = 2'b00;
      g = model_grant(req_valid, m_last);
      if (!rst && !m_busy) exp_rdy[g] = req_valid[g];
      chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, (m_busy && m_age >= 1)});
      chk("dp_a", {32'd0, dp_a}, {32'd0, m_a});
      chk("dp_b", {32'd0, dp_b}, {32'd0, m_b});
      chk("dp_opcode", {59'd0, dp_opcode}, {59'd0, m_op});
      if (m_busy && m_age >= 1) begin
        chk("resp_id", {63'd0, resp_id}, {63'd0, m_id});
        chk("resp_sum", {32'd0, resp_sum}, {32'd0, m_exp.sum});
        chk("resp_flags", {60'd0, resp_cout, resp_neg, resp_ovf, resp_zero},
            {60'd0, m_exp.cout, m_exp.neg, m_exp.ovf, m_exp.zero});
      end
    end
  end

  task automatic arm(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    if (idx == 0) begin
      req0_a = a; req0_b = b; req0_opcode = op;
    end else begin
      req1_a = a; req1_b = b; req1_opcode = op;
    end
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_acc(input int idx, output int waited);
    waited = 0;
    #1;
    while (!req_ready[idx] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[idx]) begin
      n_chk++;
      $display("FAIL accept_timeout req%0d: ready never rose, want handshake", idx);
    end
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic get_resp(input bit id, input logic [31:0] sum, input bit cout, input bit neg, input bit zero);
    int n;
    n = 0;
    #1;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      n_chk++;
      $display("FAIL resp_timeout: resp_valid never rose, want id %0d", id);
    end
    chk("lit_id", {63'd0, resp_id}, {63'd0, id});
    chk("lit_sum", {32'd0, resp_sum}, {32'd0, sum});
    chk("lit_cnz", {61'd0, resp_cout, resp_neg, resp_zero}, {61'd0, cout, neg, zero});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    bit ids [3];

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_dp", {dp_a, dp_b}, 64'd0);
    chk("rst_resp", {31'd0, resp_id, resp_sum}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Single request, ADD_U: ready same cycle, resp_valid two cycles after handshake.
    arm(0, 32'd7, 32'd2, 5'b00001);
    wait_acc(0, w);
    chk("t1_ready_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("t1_exec_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("t1_resp_at_2", {63'd0, resp_valid}, 64'd1);
    get_resp(1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0);

    // Single request, TC_SUM from requester 1.
    arm(1, 32'd7, 32'd2, 5'b00010);
    wait_acc(1, w);
    get_resp(1'b1, 32'hFFFF_FFF7, 1'b0, 1'b1, 1'b0);

    // Simultaneous requests: last grant was 1, so requester 0 goes first.
    arm(0, -32'sd7, 32'd2, 5'b00001);
    arm(1, -32'sd7, -32'sd2, 5'b00001);
    wait_acc(0, w);
    get_resp(1'b0, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0);
    wait_acc(1, w);
    get_resp(1'b1, 32'hFFFF_FFF7, 1'b1, 1'b1, 1'b0);

    // Back-pressure with requester 1 waiting on an unknown opcode.
    resp_ready = 1'b0;
    arm(1, 32'd5, 32'd5, 5'b00011);
    arm(0, 32'd100, 32'd23, 5'b00001);
    wait_acc(0, w);
    while (!resp_valid) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_resp_sum", {32'd0, resp_sum}, 64'd123);
      chk("bp_req_ready", {62'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    get_resp(1'b0, 32'd123, 1'b0, 1'b0, 1'b0);
    wait_acc(1, w);
    chk("unk_opcode_fwd", {59'd0, dp_opcode}, 64'd3);
    get_resp(1'b1, 32'd0, 1'b0, 1'b0, 1'b1);

    // Reset while in EXEC drops the operation.
    arm(1, 32'd1, 32'd1, 5'b00001);
    wait_acc(1, w);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_dp", {dp_a, dp_b}, 64'd0);
    chk("mid_rst_opcode", {59'd0, dp_opcode}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_no_resp", {63'd0, resp_valid}, 64'd0);
    arm(0, -32'sd7, 32'd2, 5'b00001);
    arm(1, -32'sd7, -32'sd2, 5'b00001);
    wait_acc(0, w);
    get_resp(1'b0, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0);
    wait_acc(1, w);
    get_resp(1'b1, 32'hFFFF_FFF7, 1'b1, 1'b1, 1'b0);

    // Both held continuously for three operations.
    arm(0, 32'd1, 32'd1, 5'b00001);
    arm(1, 32'd3, 32'd4, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      #1;
      while (!resp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      ids[i] = resp_id;
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
`ifdef ADD_ARB_FIXED_PRIO_EN
    chk("hold_ids", {61'd0, ids[0], ids[1], ids[2]}, 64'b000);
`else
    chk("hold_ids", {61'd0, ids[0], ids[1], ids[2]}, 64'b010);
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
